uram_access_arbiter: RTL

Arbiter and sequencer for the 16-lane × 72-bit (1152-bit) URAM row bank used by graph build. It shares the single-port bank between a write requester (event/feature insertion) and a read requester (neighbour lookup) with round-robin fairness. It owns a hardware clear sequence that zeroes every row after reset or on command. All memory-side signals are registered; read responses are returned in order with fixed latency.

---
 rtl/uram_access_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uram_access_arbiter
// Purpose  : Round-robin write/read arbiter and clear sequencer for a
//            single-port URAM row bank, with in-order fixed-latency reads.
// Revision : 1.0 - initial release
// ============================================================================
module uram_access_arbiter #(
    parameter int DEPTH  = 12000,
    parameter int AW     = $clog2(DEPTH),
    parameter int DW     = 1152,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          clr_start,
    output logic          clr_busy,

    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,

    input  logic          rd_valid,
    output logic          rd_ready,
    input  logic [AW-1:0] rd_addr,

    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,

    output logic          err_oob,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [0:0]  ST_CLEAR = 1'b0;
    localparam logic [0:0]  ST_SERVE = 1'b1;
    // One extra bit so the clear counter can reach DEPTH itself.
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);

    logic [0:0]    state_q,     state_d;
    logic [AW:0]   cnt_q,       cnt_d;
    logic          prefer_wr_q, prefer_wr_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_din_q,   mem_din_d;
    logic          err_oob_q,   err_oob_d;
    logic [RD_LAT:0] tok_q,     tok_d;
    logic [RD_LAT:0] tok_oob_q, tok_oob_d;

    logic serving;
    logic grant_wr;
    logic grant_rd;
    logic wr_oob;
    logic rd_oob;

    // clr_start takes priority over any pending request in the same cycle.
    assign serving  = (state_q == ST_SERVE) && !clr_start;
    assign grant_wr = serving && wr_valid && (!rd_valid || prefer_wr_q);
    assign grant_rd = serving && rd_valid && (!wr_valid || !prefer_wr_q);
    assign wr_oob   = {1'b0, wr_addr} >= DEPTH_C;
    assign rd_oob   = {1'b0, rd_addr} >= DEPTH_C;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prefer_wr_d = prefer_wr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        err_oob_d   = err_oob_q;
        tok_d       = {tok_q[RD_LAT-1:0], 1'b0};
        tok_oob_d   = {tok_oob_q[RD_LAT-1:0], 1'b0};

        if (state_q == ST_CLEAR) begin
            if (cnt_q < DEPTH_C) begin
                mem_we_d   = 1'b1;
                mem_addr_d = cnt_q[AW-1:0];
                mem_din_d  = '0;
                cnt_d      = cnt_q + 1'b1;
            end else begin
                state_d = ST_SERVE;
                cnt_d   = '0;
            end
        end else begin
            if (clr_start) begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end else if (grant_wr) begin
                prefer_wr_d = 1'b0;
                if (wr_oob) begin
                    err_oob_d = 1'b1;
                end else begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = wr_addr;
                    mem_din_d  = wr_data;
                end
            end else if (grant_rd) begin
                prefer_wr_d  = 1'b1;
                tok_d[0]     = 1'b1;
                tok_oob_d[0] = rd_oob;
                // An out-of-range read never touches the bank; its data is masked.
                if (rd_oob) begin
                    err_oob_d = 1'b1;
                end else begin
                    mem_addr_d = rd_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            prefer_wr_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            err_oob_q   <= 1'b0;
            tok_q       <= '0;
            tok_oob_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prefer_wr_q <= prefer_wr_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            err_oob_q   <= err_oob_d;
            tok_q       <= tok_d;
            tok_oob_q   <= tok_oob_d;
        end
    end

    assign clr_busy  = (state_q == ST_CLEAR);
    assign wr_ready  = grant_wr;
    assign rd_ready  = grant_rd;
    assign err_oob   = err_oob_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign rsp_valid = tok_q[RD_LAT];
    assign rsp_data  = (tok_q[RD_LAT] && !tok_oob_q[RD_LAT]) ? mem_dout : '0;

endmodule
`default_nettype wire
